// File: rtl/sd_bmp_frame_writer_pkg.sv
// Shared types and constants for the BMP frame writer.
package sd_bmp_frame_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } fw_state_e;

   // 480x272 RGB565 panel
   localparam int unsigned FRAME_PIXELS_DEF = 130560;
   localparam int unsigned WORD_W           = 128;
   localparam int unsigned PIX_W            = 16;
   localparam int unsigned PIX_PER_WORD     = WORD_W / PIX_W;

endpackage

// File: rtl/sync_fifo_w.sv
// Synchronous word FIFO with a registered head word.
// Read-before-write: a push and a pop in the same cycle both succeed, even
// when full, and occupancy stays unchanged.
module sync_fifo_w #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [AW:0]      cnt_after_pop;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = head_q;

   // Pointer, count and next-head computation
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      cnt_after_pop = cnt_q - {{AW{1'b0}}, do_pop};
      cnt_d         = cnt_after_pop + {{AW{1'b0}}, do_push};
      head_d        = head_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      // The head register tracks mem[rd_ptr]; a word pushed into a FIFO that
      // is (or is becoming) empty bypasses the array straight into the head.
      if (cnt_after_pop == '0) begin
         if (do_push) begin
            head_d = din;
         end
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         head_d   = '0;
      end
   end

   // Control and head registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

   // Storage array write
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/sd_bmp_frame_writer.sv
// Packs RGB565 pixels from the BMP reader into 128-bit words and streams them
// to DDR3 at consecutive addresses from a per-frame base.
module sd_bmp_frame_writer
   import sd_bmp_frame_writer_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter int unsigned ADDR_WIDTH   = 28,
   parameter int unsigned ADDR_STEP    = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] frame_base,
   input  logic                  write_req,
   output logic                  write_req_ack,
   input  logic                  write_en,
   input  logic [PIX_W-1:0]      write_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [WORD_W-1:0]     wr_data,
   output logic                  frame_done,
   output logic                  overflow,
   output logic                  busy
);

   localparam int unsigned      CNT_W    = $clog2(FRAME_PIXELS + 1);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

   fw_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0]    base_q, base_d;
   logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0]         word_idx_q, word_idx_d;
   logic [WORD_W-PIX_W-1:0]  pack_q, pack_d;
   logic [WORD_W-1:0]        push_word_q, push_word_d;
   logic                     push_q, push_d;
   logic                     ovf_q, ovf_d;

   logic [2:0] slot;
   logic       streaming;
   logic       accept_pix;
   logic       last_pix;
   logic       drain_done;
   logic       fifo_full, fifo_empty, fifo_pop, fifo_flush;

   assign slot       = pix_cnt_q[2:0];
   assign streaming  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign accept_pix = (state_q == ST_RUN) && write_en && !write_req;
   assign last_pix   = accept_pix && (pix_cnt_q == LAST_PIX);
   assign drain_done = (state_q == ST_DRAIN) && fifo_empty && !push_q;
   assign fifo_pop   = wr_valid && wr_ready;
   assign fifo_flush = (state_q == ST_ACK);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; write_req during a frame aborts it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (write_req) state_d = ST_ACK;
         ST_ACK:   state_d = ST_RUN;
         ST_RUN: begin
            if (write_req)     state_d = ST_ACK;
            else if (last_pix) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (write_req)       state_d = ST_ACK;
            else if (drain_done) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode; rst and abort drop wr_valid in the same cycle
   always_comb begin
      write_req_ack = (state_q == ST_ACK);
      busy          = (state_q != ST_IDLE);
      wr_valid      = streaming && !fifo_empty && !write_req && !rst;
      frame_done    = drain_done && !write_req && !rst;
   end

   // Packer, counters and overflow next-state
   always_comb begin
      base_d      = base_q;
      pix_cnt_d   = pix_cnt_q;
      word_idx_d  = word_idx_q;
      pack_d      = pack_q;
      push_word_d = push_word_q;
      push_d      = 1'b0;
      ovf_d       = ovf_q;
      if (state_q == ST_ACK) begin
         base_d     = frame_base;
         pix_cnt_d  = '0;
         word_idx_d = '0;
         pack_d     = '0;
         ovf_d      = 1'b0;
      end else begin
         if (accept_pix) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            // Only seven slots are stored; the eighth pixel completes the
            // word directly into the push register.
            if (slot == 3'(PIX_PER_WORD - 1)) begin
               push_d      = 1'b1;
               push_word_d = {write_data, pack_q};
            end else begin
               for (int unsigned i = 0; i < PIX_PER_WORD - 1; i++) begin
                  if (slot == 3'(i)) begin
                     pack_d[i*PIX_W +: PIX_W] = write_data;
                  end
               end
            end
         end
         if (fifo_pop) begin
            word_idx_d = word_idx_q + 1'b1;
         end
         if (push_q && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q      <= '0;
         pix_cnt_q   <= '0;
         word_idx_q  <= '0;
         pack_q      <= '0;
         push_word_q <= '0;
         push_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         base_q      <= base_d;
         pix_cnt_q   <= pix_cnt_d;
         word_idx_q  <= word_idx_d;
         pack_q      <= pack_d;
         push_word_q <= push_word_d;
         push_q      <= push_d;
         ovf_q       <= ovf_d;
      end
   end

   assign overflow = ovf_q;
   assign wr_addr  = base_q + (ADDR_WIDTH'(word_idx_q) * ADDR_WIDTH'(ADDR_STEP));

   sync_fifo_w #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (push_q),
      .din   (push_word_q),
      .pop   (fifo_pop),
      .dout  (wr_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_sd_bmp_frame_writer.sv
// Directed bench: a 16-pixel-frame instance (A) and an 80-pixel-frame
// instance (B) share all inputs; each scenario checks the relevant one.
module tb_sd_bmp_frame_writer;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [27:0]   frame_base = '0;
   logic          write_req = 1'b0;
   logic          write_en = 1'b0;
   logic [15:0]   write_data = '0;
   logic          wr_ready = 1'b0;

   logic          a_ack, a_valid, a_done, a_ovf, a_busy;
   logic [27:0]   a_addr;
   logic [127:0]  a_data;
   logic          b_ack, b_valid, b_done, b_ovf, b_busy;
   logic [27:0]   b_addr;
   logic [127:0]  b_data;

   int checks = 0;
   int errors = 0;

   logic [27:0]  qa_addr[$], qb_addr[$];
   logic [127:0] qa_data[$], qb_data[$];
   int           a_done_cnt = 0, b_done_cnt = 0;
   logic         b_stall = 1'b0;
   logic [27:0]  b_prev_addr = '0;
   logic [127:0] b_prev_data = '0;

   typedef struct {
      logic [27:0]  base;
      logic [15:0]  p0;
      logic [27:0]  addr0;
      logic [27:0]  addr1;
      logic [127:0] word0;
      logic [127:0] word1;
   } vec_t;
   vec_t tv[3];

   sd_bmp_frame_writer #(
      .FRAME_PIXELS (16), .ADDR_WIDTH (28), .ADDR_STEP (16), .FIFO_DEPTH (8)
   ) dut_a (
      .clk (clk), .rst (rst), .frame_base (frame_base), .write_req (write_req),
      .write_req_ack (a_ack), .write_en (write_en), .write_data (write_data),
      .wr_valid (a_valid), .wr_ready (wr_ready), .wr_addr (a_addr),
      .wr_data (a_data), .frame_done (a_done), .overflow (a_ovf), .busy (a_busy)
   );

   sd_bmp_frame_writer #(
      .FRAME_PIXELS (80), .ADDR_WIDTH (28), .ADDR_STEP (16), .FIFO_DEPTH (8)
   ) dut_b (
      .clk (clk), .rst (rst), .frame_base (frame_base), .write_req (write_req),
      .write_req_ack (b_ack), .write_en (write_en), .write_data (write_data),
      .wr_valid (b_valid), .wr_ready (wr_ready), .wr_addr (b_addr),
      .wr_data (b_data), .frame_done (b_done), .overflow (b_ovf), .busy (b_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Handshake capture, frame_done counting and stall stability on B
   always @(negedge clk) begin
      if (b_valid && b_stall) begin
         chk("b_addr_stable", 128'(b_addr), 128'(b_prev_addr));
         chk("b_data_stable", b_data, b_prev_data);
      end
      b_stall     = b_valid && !wr_ready;
      b_prev_addr = b_addr;
      b_prev_data = b_data;
      if (a_valid && wr_ready) begin
         qa_addr.push_back(a_addr);
         qa_data.push_back(a_data);
      end
      if (b_valid && wr_ready) begin
         qb_addr.push_back(b_addr);
         qb_data.push_back(b_data);
      end
      if (a_done) a_done_cnt++;
      if (b_done) b_done_cnt++;
   end

   function automatic logic [127:0] mkword(input logic [15:0] p0);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w[i*16 +: 16] = p0 + 16'(i);
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      write_req = 1'b0;
      write_en = 1'b0;
      write_data = '0;
      tick();
      tick();
      rst = 1'b0;
      qa_addr.delete(); qa_data.delete();
      qb_addr.delete(); qb_data.delete();
      a_done_cnt = 0;
      b_done_cnt = 0;
   endtask

   task automatic send_pix(input logic [15:0] v, input int gap);
      write_en = 1'b1;
      write_data = v;
      tick();
      write_en = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic start_frame(input logic [27:0] base);
      frame_base = base;
      write_req = 1'b1;
      tick();
      write_req = 1'b0;
      tick();
   endtask

   task automatic wait_a_done();
      for (int n = 0; n < 300 && a_done_cnt == 0; n++) tick();
   endtask

   task automatic wait_b_done();
      for (int n = 0; n < 400 && b_done_cnt == 0; n++) tick();
   endtask

   initial begin
      tv[0] = '{28'h0000100, 16'h0001, 28'h0000100, 28'h0000110,
                128'h0008_0007_0006_0005_0004_0003_0002_0001,
                128'h0010_000F_000E_000D_000C_000B_000A_0009};
      tv[1] = '{28'h0002000, 16'h1000, 28'h0002000, 28'h0002010,
                128'h1007_1006_1005_1004_1003_1002_1001_1000,
                128'h100F_100E_100D_100C_100B_100A_1009_1008};
      tv[2] = '{28'hFFFFFF0, 16'hFFF8, 28'hFFFFFF0, 28'h0000000,
                128'hFFFF_FFFE_FFFD_FFFC_FFFB_FFFA_FFF9_FFF8,
                128'h0007_0006_0005_0004_0003_0002_0001_0000};

      // Reset values, sampled while rst is still asserted
      tick();
      chk("rst_busy", 128'(a_busy), 128'(0));
      chk("rst_ack", 128'(a_ack), 128'(0));
      chk("rst_valid", 128'(a_valid), 128'(0));
      chk("rst_addr", 128'(a_addr), 128'(0));
      chk("rst_data", a_data, 128'(0));
      chk("rst_ovf", 128'(a_ovf), 128'(0));
      chk("rst_done", 128'(a_done), 128'(0));

      // Table-driven full frames on A with wr_ready high
      for (int t = 0; t < 3; t++) begin
         do_reset();
         wr_ready = 1'b1;
         frame_base = tv[t].base;
         write_req = 1'b1;
         tick();
         chk("ack_pulse", 128'(a_ack), 128'(1));
         write_req = 1'b0;
         tick();
         chk("ack_one_cycle", 128'(a_ack), 128'(0));
         chk("run_busy", 128'(a_busy), 128'(1));
         for (int i = 0; i < 16; i++) send_pix(tv[t].p0 + 16'(i), 0);
         wait_a_done();
         chk("tv_nwords", 128'(qa_addr.size()), 128'(2));
         if (qa_addr.size() == 2) begin
            chk("tv_addr0", 128'(qa_addr[0]), 128'(tv[t].addr0));
            chk("tv_addr1", 128'(qa_addr[1]), 128'(tv[t].addr1));
            chk("tv_word0", qa_data[0], tv[t].word0);
            chk("tv_word1", qa_data[1], tv[t].word1);
         end
         tick();
         chk("tv_done_cnt", 128'(a_done_cnt), 128'(1));
         chk("tv_idle", 128'(a_busy), 128'(0));
         chk("tv_ovf", 128'(a_ovf), 128'(0));
      end

      // Stall for 40 cycles while pixels arrive every third cycle
      do_reset();
      wr_ready = 1'b0;
      start_frame(28'h0004000);
      fork
         begin
            for (int i = 0; i < 64; i++) send_pix(16'h0100 + 16'(i), 2);
         end
         begin
            repeat (40) tick();
            wr_ready = 1'b1;
         end
      join
      for (int i = 64; i < 80; i++) send_pix(16'h0100 + 16'(i), 0);
      wait_b_done();
      tick();
      chk("stall_nwords", 128'(qb_addr.size()), 128'(10));
      for (int k = 0; k < 10 && k < qb_addr.size(); k++) begin
         chk("stall_addr", 128'(qb_addr[k]), 128'(28'h0004000 + 28'(16 * k)));
         chk("stall_word", qb_data[k], mkword(16'h0100 + 16'(8 * k)));
      end
      chk("stall_ovf", 128'(b_ovf), 128'(0));
      chk("stall_done", 128'(b_done_cnt), 128'(1));

      // Held stall: the 9th and 10th words overflow
      do_reset();
      wr_ready = 1'b0;
      start_frame(28'h0008000);
      for (int i = 0; i < 80; i++) begin
         send_pix(16'h0200 + 16'(i), 0);
         if (i == 63) begin
            tick();
            chk("ovf_at_8", 128'(b_ovf), 128'(0));
            chk("ovf_valid", 128'(b_valid), 128'(1));
         end
         if (i == 71) begin
            tick();
            chk("ovf_at_9", 128'(b_ovf), 128'(1));
         end
      end
      tick();
      wr_ready = 1'b1;
      wait_b_done();
      tick();
      chk("ovf_nwords", 128'(qb_addr.size()), 128'(8));
      for (int k = 0; k < 8 && k < qb_addr.size(); k++) begin
         chk("ovf_addr", 128'(qb_addr[k]), 128'(28'h0008000 + 28'(16 * k)));
         chk("ovf_word", qb_data[k], mkword(16'h0200 + 16'(8 * k)));
      end
      chk("ovf_done", 128'(b_done_cnt), 128'(1));
      chk("ovf_sticky", 128'(b_ovf), 128'(1));

      // Abort after five words, restart at a new base
      do_reset();
      wr_ready = 1'b1;
      start_frame(28'h0001000);
      for (int i = 0; i < 40; i++) send_pix(16'h0400 + 16'(i), 0);
      for (int n = 0; n < 20 && qb_addr.size() < 5; n++) tick();
      chk("abort_pre_words", 128'(qb_addr.size()), 128'(5));
      frame_base = 28'h0002000;
      write_req = 1'b1;
      tick();
      chk("abort_ack", 128'(b_ack), 128'(1));
      chk("abort_valid", 128'(b_valid), 128'(0));
      write_req = 1'b0;
      tick();
      chk("abort_new_addr", 128'(b_addr), 128'(28'h0002000));
      chk("abort_no_done", 128'(b_done_cnt), 128'(0));
      chk("abort_ovf_clr", 128'(b_ovf), 128'(0));
      for (int i = 0; i < 80; i++) send_pix(16'h0300 + 16'(i), 0);
      wait_b_done();
      tick();
      chk("abort_total", 128'(qb_addr.size()), 128'(15));
      if (qb_addr.size() > 5) begin
         chk("abort_first_addr", 128'(qb_addr[5]), 128'(28'h0002000));
         chk("abort_first_word", qb_data[5], mkword(16'h0300));
      end
      chk("abort_done", 128'(b_done_cnt), 128'(1));

      // rst mid-RUN with wr_valid high
      do_reset();
      wr_ready = 1'b0;
      start_frame(28'h0000500);
      for (int i = 0; i < 8; i++) send_pix(16'h0500 + 16'(i), 0);
      tick();
      chk("rstmid_valid_pre", 128'(b_valid), 128'(1));
      rst = 1'b1;
      #1;
      chk("rstmid_valid_drop", 128'(b_valid), 128'(0));
      tick();
      rst = 1'b0;
      chk("rstmid_busy", 128'(b_busy), 128'(0));
      chk("rstmid_addr", 128'(b_addr), 128'(0));
      chk("rstmid_data", b_data, 128'(0));
      chk("rstmid_ack", 128'(b_ack), 128'(0));
      chk("rstmid_ovf", 128'(b_ovf), 128'(0));
      wr_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_pix(16'h0600, 0);
      tick();
      tick();
      chk("rstmid_idle_busy", 128'(b_busy), 128'(0));
      chk("rstmid_idle_valid", 128'(b_valid), 128'(0));
      chk("rstmid_idle_words", 128'(qb_addr.size()), 128'(0));
      chk("rstmid_no_done", 128'(b_done_cnt), 128'(0));

      // write_en ignored in IDLE and after the last pixel of a frame
      do_reset();
      wr_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_pix(16'hEEEE, 0);
      tick();
      chk("idle_en_busy", 128'(a_busy), 128'(0));
      chk("idle_en_addr", 128'(a_addr), 128'(0));
      chk("idle_en_valid", 128'(a_valid), 128'(0));
      wr_ready = 1'b0;
      start_frame(28'h0000700);
      for (int i = 0; i < 16; i++) send_pix(16'h0A00 + 16'(i), 0);
      for (int i = 0; i < 8; i++) send_pix(16'hDDDD, 0);
      tick();
      chk("drain_addr_hold", 128'(a_addr), 128'(28'h0000700));
      chk("drain_busy", 128'(a_busy), 128'(1));
      wr_ready = 1'b1;
      wait_a_done();
      tick();
      chk("drain_nwords", 128'(qa_addr.size()), 128'(2));
      if (qa_addr.size() >= 2) begin
         chk("drain_word0", qa_data[0], mkword(16'h0A00));
         chk("drain_word1", qa_data[1], mkword(16'h0A08));
         chk("drain_addr1", 128'(qa_addr[1]), 128'(28'h0000710));
      end
      chk("drain_done", 128'(a_done_cnt), 128'(1));
      for (int i = 0; i < 8; i++) send_pix(16'hCCCC, 0);
      tick();
      tick();
      chk("post_addr", 128'(a_addr), 128'(28'h0000720));
      chk("post_valid", 128'(a_valid), 128'(0));
      chk("post_words", 128'(qa_addr.size()), 128'(2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
